// File: rtl/timer_pkg.sv
// Shared timer definitions: external trigger mode encodings, input-conditioning
// defaults and the ETM command decode used by the external-input stage.
package timer_pkg;

  localparam int TIM_SYNC_STAGES = 2;
  localparam int TIM_FLT_WIDTH   = 4;

  typedef enum logic [2:0] {
    TIM_ETM_NONE = 3'b000,
    TIM_ETM_RISE = 3'b001,
    TIM_ETM_FALL = 3'b010,
    TIM_ETM_CLER = 3'b011,
    TIM_ETM_LOAD = 3'b100
  } tim_etm_e;

  typedef struct packed {
    logic inc;
    logic clr;
    logic load;
  } tim_cmd_t;

  // Reserved encodings (101..111) fall through to no command.
  function automatic tim_cmd_t tim_etm_decode(input logic [2:0] etm,
                                              input logic       rise,
                                              input logic       fall);
    tim_cmd_t cmd;
    cmd = '0;
    case (etm)
      TIM_ETM_RISE: cmd.inc  = rise;
      TIM_ETM_FALL: cmd.inc  = fall;
      TIM_ETM_CLER: cmd.clr  = rise;
      TIM_ETM_LOAD: cmd.load = rise;
      default:      cmd      = '0;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/timer_sigcond.sv
// One conditioned input: synchroniser, length-N glitch filter and edge detector.
// SYNC_STAGES is legal from 2 to 4.
module timer_sigcond
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = TIM_SYNC_STAGES,
  parameter int FLT_WIDTH   = TIM_FLT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [FLT_WIDTH-1:0] flt_i,
  input  logic                 din_i,
  output logic                 lvl_o,
  output logic                 rise_o,
  output logic                 fall_o
);

  // After reset the chain is still empty; track the input without edges until
  // it has filled, so a static high input does not look like a fresh rise.
  localparam int WARM_INIT = SYNC_STAGES + 1;
  localparam int WARM_W    = $clog2(WARM_INIT + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   flt_q;
  logic                   dly_q;
  logic                   armed_q;
  logic [FLT_WIDTH-1:0]   cnt_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   active;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign active   = en_i & (warm_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      flt_q   <= 1'b0;
      dly_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      warm_q  <= WARM_W'(WARM_INIT);
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
      dly_q   <= flt_q;
      armed_q <= active;
      if (warm_q != '0) begin
        warm_q <= warm_q - WARM_W'(1);
      end
      if (!active) begin
        flt_q <= sync_lvl;
        cnt_q <= '0;
      end else if (sync_lvl == flt_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= flt_i) begin
        // >= so a filter length lowered mid-count still flips at once
        flt_q <= sync_lvl;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + FLT_WIDTH'(1);
      end
    end
  end

  // armed_q hides the one-cycle f/fd difference left by a disabled-mode update.
  assign lvl_o  = flt_q;
  assign rise_o = armed_q & flt_q & ~dly_q;
  assign fall_o = armed_q & ~flt_q & dly_q;

endmodule

// File: rtl/timer_extin.sv
// External-input stage of the timer: conditions exclk/capch and turns their
// edges into registered single-cycle count/clear/load/capture commands.
module timer_extin
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = TIM_SYNC_STAGES,
  parameter int FLT_WIDTH   = TIM_FLT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [2:0]           etm_i,
  input  logic [FLT_WIDTH-1:0] flt_i,
  input  logic                 exclk_i,
  input  logic                 capch_i,
  output logic                 cnt_inc_o,
  output logic                 cnt_clr_o,
  output logic                 cnt_load_o,
  output logic                 cap_o,
  output logic                 exclk_lvl_o
);

  logic     ex_lvl;
  logic     ex_rise;
  logic     ex_fall;
  logic     cap_lvl;
  logic     cap_rise;
  logic     cap_fall;
  logic     unused_cap;
  tim_cmd_t cmd;

  timer_sigcond #(
    .SYNC_STAGES(SYNC_STAGES),
    .FLT_WIDTH  (FLT_WIDTH)
  ) u_exclk (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .flt_i  (flt_i),
    .din_i  (exclk_i),
    .lvl_o  (ex_lvl),
    .rise_o (ex_rise),
    .fall_o (ex_fall)
  );

  timer_sigcond #(
    .SYNC_STAGES(SYNC_STAGES),
    .FLT_WIDTH  (FLT_WIDTH)
  ) u_capch (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .flt_i  (flt_i),
    .din_i  (capch_i),
    .lvl_o  (cap_lvl),
    .rise_o (cap_rise),
    .fall_o (cap_fall)
  );

  // Capture only reacts to rising edges.
  assign unused_cap = cap_lvl ^ cap_fall;

  always_comb begin
    cmd = tim_etm_decode(etm_i, ex_rise, ex_fall);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_inc_o   <= 1'b0;
      cnt_clr_o   <= 1'b0;
      cnt_load_o  <= 1'b0;
      cap_o       <= 1'b0;
      exclk_lvl_o <= 1'b0;
    end else begin
      cnt_inc_o   <= en_i & cmd.inc;
      cnt_clr_o   <= en_i & cmd.clr;
      cnt_load_o  <= en_i & cmd.load;
      cap_o       <= en_i & cap_rise;
      exclk_lvl_o <= ex_lvl;
    end
  end

endmodule

// File: doc/timer_extin.md
Name: timer_extin

Overview:
- Input-conditioning stage directly upstream of the timer counter core.
- Takes the asynchronous external clock/trigger (exclk_i) and the capture channel (capch_i) from the timer_if dut modport.
- Synchronises and glitch-filters both signals, then edge-detects them.
- Produces single-cycle, registered command pulses (count, clear, load, capture) that the counter core consumes according to CTRL.ETM and CTRL.EEN.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input (legal 2..4).
- FLT_WIDTH, 4, width of the filter length field and filter counters.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  CTRL.EN & CTRL.EEN from the register block.
- etm_i  in  3  CTRL.ETM field; TIM_ETM_* encodings.
- flt_i  in  FLT_WIDTH  filter length N; 0 bypasses the filter.
- exclk_i  in  1  raw asynchronous external clock/trigger.
- capch_i  in  1  raw asynchronous capture input.
- cnt_inc_o  out  1  one-cycle pulse: increment the counter.
- cnt_clr_o  out  1  one-cycle pulse: clear the counter.
- cnt_load_o  out  1  one-cycle pulse: load the counter from CMP.
- cap_o  out  1  one-cycle pulse: capture the current count.
- exclk_lvl_o  out  1  filtered exclk level, for status/debug.

Behaviour:
- Reset: all synchroniser flops, filtered levels, delayed levels, filter counters and all outputs are 0.
- Per-input path (identical for exclk_i and capch_i):
  - Sync chain s[0..SYNC_STAGES-1]; sl = s[SYNC_STAGES-1].
  - Filtered level f and counter c.
  - If sl == f: c <= 0.
  - If sl != f and c == flt_i: f <= sl and c <= 0.
  - Otherwise: c <= c+1.
  - Net effect: f follows sl after sl has differed from f for flt_i+1 consecutive cycles. Pulses on sl shorter than flt_i+1 cycles are rejected and leave f unchanged.
  - fd <= f. Rise = f & ~fd; fall = ~f & fd.
- Latency: an input transition meeting setup at edge 1 produces an output pulse high after edge SYNC_STAGES+2+flt_i. With defaults and flt_i=0, that is after edge 4. Each pulse is high for exactly 1 cycle.
- Output decode. All outputs are registered and are 0 when en_i=0.
  - ETM NONE (000): no exclk pulses.
  - ETM RISE (001): cnt_inc_o on each exclk rise.
  - ETM FALL (010): cnt_inc_o on each exclk fall.
  - ETM CLER (011): cnt_clr_o on each exclk rise.
  - ETM LOAD (100): cnt_load_o on each exclk rise.
  - ETM 101..111: reserved; no exclk pulses.
  - cap_o on each capch rise, independent of etm_i.
- At most one of cnt_inc_o/cnt_clr_o/cnt_load_o is high in any cycle. cap_o may coincide with any of them.
- Disabled (en_i=0):
  - Sync chains keep running.
  - f <= sl directly, c <= 0, fd <= f.
  - Result: on the rising edge of en_i, no spurious edge is produced from a static high input.
- etm_i and flt_i are sampled every cycle; a change takes effect on the next edge. A reduction of flt_i below the current c value causes a flip at the next mismatch cycle (c >= flt_i is treated as match-reached).
- exclk_lvl_o = registered copy of f for exclk.
- Reset asserted mid-operation: all state clears immediately (async); no pulse is emitted during or on release of reset.
- Maximum tracked input frequency: clk_i/(2*(flt_i+1)). Faster toggling is filtered out; this is not an error.

Decomposition:
- Shared package timer_pkg:
  - ETM encodings as an enum, matching TIM_ETM_* values.
  - SYNC_STAGES and FLT_WIDTH defaults.
- Sub-module timer_sigcond:
  - Contains the synchroniser, filter counter, edge detector and rise/fall outputs.
  - Parameters SYNC_STAGES, FLT_WIDTH.
  - Instantiated twice, once per input.
- timer_extin holds the ETM decode, enable gating and output registers.

Test Plan:
- Bypass count: en_i=1, etm=RISE, flt=0, exclk square wave with 8-cycle period for 10 periods -> exactly 10 cnt_inc_o pulses, each 1 cycle wide, first pulse high after edge 4 following the first rise.
- Glitch reject: flt=3, exclk high for 3 cycles then low -> no pulses. exclk high for 4 cycles -> one cnt_inc_o pulse at edge 4+3 after the rise.
- Mode decode: etm=FALL/CLER/LOAD/101 with one full exclk pulse each -> respectively one cnt_inc_o on the fall, one cnt_clr_o on the rise, one cnt_load_o on the rise, and no pulses for 101. Never more than one of the three outputs high in a cycle.
- Enable gating: exclk held high, en_i 0->1 -> no pulse. Toggling exclk while en_i=0 -> no pulses. After enable, a falling-then-rising exclk gives one pulse.
- Capture: etm=NONE, capch rising edge simultaneous with exclk rising edge under etm=RISE -> cap_o and cnt_inc_o high in the same cycle. With etm=NONE, cap_o alone.
- Reset mid-stream: assert rst_n_i low while an exclk rise is in the sync chain -> all outputs 0 immediately, and no pulse after release with exclk still high and en_i=1.
